button_debouncer: RTL and testbench

//   Input-side counterpart of the board's switch-to-LED gates. Takes one raw,

---
 rtl/button_debouncer_pkg.sv | 27 ++
 rtl/button_debouncer_sync_ff_chain.sv | 25 ++
 rtl/button_debouncer.sv | 131 +++++++++++++
 tb/tb_button_debouncer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/button_debouncer_pkg.sv
// Shared constants for the button debouncer: board clock, FSM state encodings
// and the constant ceil-log2 used to size the stability counter.
package button_debouncer_pkg;

   localparam int unsigned CLK_FREQ_HZ = 32'd100000000;

   typedef enum logic [1:0] {
      STABLE_LOW  = 2'd0,
      WAIT_HIGH   = 2'd1,
      STABLE_HIGH = 2'd2,
      WAIT_LOW    = 2'd3
   } db_state_e;

   function automatic int unsigned ceil_log2(input int unsigned value);
      int unsigned result;
      result = 32'd0;
      for (int unsigned i = 32'd0; i < 32'd32; i++) begin
         if ((64'd1 << i) < {32'd0, value}) begin
            result = i + 32'd1;
         end else begin
            result = result;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/button_debouncer_sync_ff_chain.sv
// sync_ff_chain: plain N-stage flip-flop synchronizer for asynchronous board
// inputs; every stage clears to 0 on the synchronous reset.
module sync_ff_chain #(
   parameter int unsigned STAGES = 32'd2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain_r;

   // shift the raw level through the chain, no logic between stages
   always_ff @(posedge clk) begin
      if (rst) begin
         chain_r <= {STAGES{1'b0}};
      end else begin
         chain_r <= {chain_r[STAGES-2:0], d};
      end
   end

   assign q = chain_r[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: synchronizes a raw button level, rejects bounce and emits
// a clean level with rise/fall strobes. Define BUTTON_DEBOUNCER_ACTIVE_LOW_EN for active-low pins.
module button_debouncer
   import button_debouncer_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 32'd1000000,
   parameter int unsigned SYNC_STAGES     = 32'd2
) (
   input  logic clk,
   input  logic rst,
   input  logic button,
   output logic button_db,
   output logic rise_pulse,
   output logic fall_pulse
);

   localparam int unsigned CNT_W_RAW = ceil_log2(DEBOUNCE_CYCLES);
   localparam int unsigned CNT_W     = (CNT_W_RAW < 32'd1) ? 32'd1 : CNT_W_RAW;
   // the edge that enters a WAIT state is already the first stable sample
   localparam logic [CNT_W-1:0] ACCEPT_COUNT = CNT_W'(DEBOUNCE_CYCLES - 32'd2);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(32'd1);
   localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};

   logic             button_in_s;
   logic             synced_s;
   db_state_e        state_r;
   db_state_e        state_s;
   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] count_s;
   logic             db_r;
   logic             db_s;
   logic             rise_r;
   logic             rise_s;
   logic             fall_r;
   logic             fall_s;

`ifdef BUTTON_DEBOUNCER_ACTIVE_LOW_EN
   assign button_in_s = ~button;
`else
   assign button_in_s = button;
`endif

   sync_ff_chain #(
      .STAGES(SYNC_STAGES)
   ) u_sync (
      .clk(clk),
      .rst(rst),
      .d  (button_in_s),
      .q  (synced_s)
   );

   // state, counter and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= STABLE_LOW;
         count_r <= CNT_ZERO;
         db_r    <= 1'b0;
         rise_r  <= 1'b0;
         fall_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         count_r <= count_s;
         db_r    <= db_s;
         rise_r  <= rise_s;
         fall_r  <= fall_s;
      end
   end

   // next-state, stability counting and strobe generation
   always_comb begin
      state_s = state_r;
      count_s = count_r;
      db_s    = db_r;
      rise_s  = 1'b0;
      fall_s  = 1'b0;
      case (state_r)
         STABLE_LOW: begin
            if (synced_s) begin
               state_s = WAIT_HIGH;
               count_s = CNT_ZERO;
            end else begin
               state_s = STABLE_LOW;
            end
         end
         WAIT_HIGH: begin
            if (!synced_s) begin
               state_s = STABLE_LOW;
               count_s = CNT_ZERO;
            end else if (count_r == ACCEPT_COUNT) begin
               state_s = STABLE_HIGH;
               count_s = CNT_ZERO;
               db_s    = 1'b1;
               rise_s  = 1'b1;
            end else begin
               count_s = count_r + CNT_ONE;
            end
         end
         STABLE_HIGH: begin
            if (!synced_s) begin
               state_s = WAIT_LOW;
               count_s = CNT_ZERO;
            end else begin
               state_s = STABLE_HIGH;
            end
         end
         WAIT_LOW: begin
            if (synced_s) begin
               state_s = STABLE_HIGH;
               count_s = CNT_ZERO;
            end else if (count_r == ACCEPT_COUNT) begin
               state_s = STABLE_LOW;
               count_s = CNT_ZERO;
               db_s    = 1'b0;
               fall_s  = 1'b1;
            end else begin
               count_s = count_r + CNT_ONE;
            end
         end
         default: begin
            state_s = STABLE_LOW;
            count_s = CNT_ZERO;
            db_s    = 1'b0;
         end
      endcase
   end

   assign button_db  = db_r;
   assign rise_pulse = rise_r;
   assign fall_pulse = fall_r;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: directed bounce/latency cases plus
// random bursts, compared every cycle against a sliding-window reference model.
module tb_button_debouncer;

   localparam int N = 8;
   localparam int S = 2;
`ifdef BUTTON_DEBOUNCER_ACTIVE_LOW_EN
   localparam bit INV = 1'b1;
`else
   localparam bit INV = 1'b0;
`endif

   logic clk;
   logic rst;
   logic button;
   logic button_db;
   logic rise_pulse;
   logic fall_pulse;

   int n_checks = 0;
   int n_fail   = 0;
   int rises    = 0;
   int falls    = 0;

   bit act;
   bit samp_q[$];
   bit obs_q[$];
   bit m_db, m_rise, m_fall;

   button_debouncer #(
      .DEBOUNCE_CYCLES(N),
      .SYNC_STAGES    (S)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .button    (button),
      .button_db (button_db),
      .rise_pulse(rise_pulse),
      .fall_pulse(fall_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic drive(input bit a);
      act    = a;
      button = a ^ INV;
   endtask

   // Reference: the FSM sees the active level S edges late; the debounced level
   // flips once the last N observations all disagree with it.
   task automatic model_edge();
      bit o;
      bit all_diff;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (rst) begin
         samp_q.delete();
         repeat (S) samp_q.push_back(1'b0);
         obs_q.delete();
         m_db = 1'b0;
      end else begin
         o = samp_q.pop_front();
         samp_q.push_back(act);
         obs_q.push_back(o);
         if (obs_q.size() > N) void'(obs_q.pop_front());
         if (obs_q.size() == N) begin
            all_diff = 1'b1;
            foreach (obs_q[i]) if (obs_q[i] == m_db) all_diff = 1'b0;
            if (all_diff) begin
               m_db = !m_db;
               if (m_db) m_rise = 1'b1;
               else      m_fall = 1'b1;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("button_db", {31'd0, button_db}, {31'd0, m_db});
      check("rise_pulse", {31'd0, rise_pulse}, {31'd0, m_rise});
      check("fall_pulse", {31'd0, fall_pulse}, {31'd0, m_fall});
      check("pulse_excl", {31'd0, rise_pulse & fall_pulse}, 32'd0);
      if (rise_pulse === 1'b1) rises++;
      if (fall_pulse === 1'b1) falls++;
   endtask

   initial begin
      int rise_at;
      int fall_at;
      repeat (S) samp_q.push_back(1'b0);
      m_db = 1'b0;
      rst  = 1'b1;
      drive(1'b1);

      // 1: reset held with button active
      for (int i = 0; i < 3; i++) begin
         tick();
         check("reset_db", {31'd0, button_db}, 32'd0);
         check("reset_pulses", {30'd0, rise_pulse, fall_pulse}, 32'd0);
      end
      rst = 1'b0;
      drive(1'b0);
      repeat (12) tick();

      // 2: clean rising step, latency S+N-1 edges
      rises = 0;
      rise_at = -1;
      drive(1'b1);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (rise_pulse === 1'b1 && rise_at < 0) rise_at = i;
      end
      check("rise_latency", rise_at, 32'd9);
      check("rise_count", rises, 32'd1);
      check("db_high", {31'd0, button_db}, 32'd1);

      // 4: bounce then hold inactive
      falls = 0;
      fall_at = -1;
      drive(1'b0); tick();
      drive(1'b1); tick();
      drive(1'b0); tick();
      drive(1'b1); tick();
      drive(1'b1); tick();
      drive(1'b0);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (fall_pulse === 1'b1 && fall_at < 0) fall_at = i;
      end
      check("fall_latency", fall_at, 32'd9);
      check("fall_count", falls, 32'd1);

      // 3: short high glitches never accepted
      rises = 0;
      falls = 0;
      for (int r = 0; r < 4; r++) begin
         drive(1'b1); repeat (3) tick();
         drive(1'b0); repeat (2) tick();
      end
      repeat (15) tick();
      check("glitch_rises", rises, 32'd0);
      check("glitch_falls", falls, 32'd0);
      check("glitch_db", {31'd0, button_db}, 32'd0);

      // 5: reset while counting, then input released
      rises = 0;
      drive(1'b1);
      repeat (8) tick();
      rst = 1'b1;
      tick();
      check("midcount_rst_db", {31'd0, button_db}, 32'd0);
      check("midcount_rst_rise", {31'd0, rise_pulse}, 32'd0);
      rst = 1'b0;
      drive(1'b0);
      repeat (15) tick();
      check("post_rst_rises", rises, 32'd0);

      // 6: long active hold gives exactly one rise
      rises = 0;
      drive(1'b1);
      repeat (12) tick();
      check("hold12_db", {31'd0, button_db}, 32'd1);
      check("hold12_rises", rises, 32'd1);

      // random bursts with occasional resets
      for (int b = 0; b < 60; b++) begin
         if ($urandom_range(0, 29) == 0) begin
            rst = 1'b1;
            repeat ($urandom_range(1, 2)) tick();
            rst = 1'b0;
         end
         drive(1'($urandom_range(0, 1)));
         repeat ($urandom_range(1, 12)) tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
